iter_sequencer: RTL and testbench



---
 rtl/iter_pkg.sv | 22 ++
 rtl/word_fifo.sv | 69 ++++++
 rtl/iter_sequencer.sv | 102 ++++++++++
 tb/tb_iter_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/iter_pkg.sv
// Shared definitions for the iterative-term sequencer and its controller.
package iter_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int TERMS_DEF  = 4;
    localparam int DEPTH_DEF  = 4;

    // Controller state codes, as decoded into read/load_y/done by the controller.
    typedef enum logic [2:0] {
        CTRL_READ   = 3'b000,
        CTRL_LOAD_X = 3'b001,
        CTRL_LOAD_Y = 3'b010,
        CTRL_BRANCH = 3'b011,
        CTRL_ACC    = 3'b100,
        CTRL_DONE   = 3'b101
    } ctrl_state_e;

    function automatic int cnt_width(input int terms);
        return (terms <= 2) ? 1 : $clog2(terms);
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous operand FIFO with registered read data; pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
module word_fifo
    import iter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                push_ok;
    logic                pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = rd_data_q;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
            rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are live, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/iter_sequencer.sv
// Host-side sequencer: feeds operands to the controller, counts iterations to
// drive the loop-exit select, and hands finished results to the host.
module iter_sequencer
    import iter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int TERMS  = TERMS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              read,
    input  logic              load_y,
    input  logic              done,
    input  logic [DATA_W-1:0] result_in,
    output logic              state_enable,
    output logic              s,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] result_out,
    output logic              result_valid,
    input  logic              result_ready
);

    localparam int                CNT_W   = cnt_width(TERMS);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TERMS - 1);

    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] result_out_q, result_out_d;
    logic              result_valid_q, result_valid_d;
    logic              capture;

    assign in_ready = !fifo_full;
    assign pop      = read && !fifo_empty;

    word_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (in_valid && in_ready),
        .pop     (pop),
        .wr_data (in_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .rd_data (x_out)
    );

    // Hold the controller whenever we cannot supply an operand or a result slot.
    always_comb begin
        state_enable = 1'b1;
        if (read && fifo_empty) begin
            state_enable = 1'b0;
        end
        if (done && result_valid_q && !result_ready) begin
            state_enable = 1'b0;
        end
    end

    assign capture = done && state_enable;
    assign s       = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d          = cnt_q;
        result_out_d   = result_out_q;
        result_valid_d = result_valid_q;
        if (pop) begin
            cnt_d = '0;
        end else if (load_y && state_enable && !read && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // A capture on the same edge as a host accept wins, keeping valid high.
        if (capture) begin
            result_out_d   = result_in;
            result_valid_d = 1'b1;
        end else if (result_valid_q && result_ready) begin
            result_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            result_out_q   <= '0;
            result_valid_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            result_out_q   <= result_out_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign result_out   = result_out_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_iter_sequencer.sv
// Self-checking bench for iter_sequencer: cycle vectors checked against a small
// behavioural model, with an operand scoreboard queue for FIFO order.
module tb_iter_sequencer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int TERMS  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              read;
    logic              load_y;
    logic              done;
    logic [DATA_W-1:0] result_in;
    logic              state_enable;
    logic              s;
    logic [DATA_W-1:0] x_out;
    logic [DATA_W-1:0] result_out;
    logic              result_valid;
    logic              result_ready;

    iter_sequencer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TERMS  (TERMS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .read         (read),
        .load_y       (load_y),
        .done         (done),
        .result_in    (result_in),
        .state_enable (state_enable),
        .s            (s),
        .x_out        (x_out),
        .result_out   (result_out),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              iv;
        logic [DATA_W-1:0] id;
        logic              rd;
        logic              ly;
        logic              dn;
        logic [DATA_W-1:0] ri;
        logic              rr;
        logic              use_exp;
        logic              exp_se;
        logic              exp_s;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [DATA_W-1:0] opq[$];
    int                m_cnt;
    logic              m_valid;
    logic [DATA_W-1:0] m_res;
    logic [DATA_W-1:0] exp_x;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [DATA_W-1:0] id, input logic rd,
                                input logic ly, input logic dn, input logic [DATA_W-1:0] ri,
                                input logic rr, input logic ue, input logic ese, input logic es);
        vec_t v;
        v.iv = iv; v.id = id; v.rd = rd; v.ly = ly; v.dn = dn;
        v.ri = ri; v.rr = rr; v.use_exp = ue; v.exp_se = ese; v.exp_s = es;
        return v;
    endfunction

    // Called at posedge+1: drive, check combinational outputs, advance model, check registers.
    task automatic cycle(input string tag, input vec_t v);
        logic m_ready, m_se, m_s, do_push, do_pop;
        in_valid = v.iv; in_data = v.id; read = v.rd; load_y = v.ly;
        done = v.dn; result_in = v.ri; result_ready = v.rr;
        #2;
        m_ready = (opq.size() < DEPTH);
        m_se    = !(v.rd && opq.size() == 0) && !(v.dn && m_valid && !v.rr);
        m_s     = (m_cnt == TERMS - 1);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(m_ready));
        check({tag, ".state_enable"}, 32'(state_enable), 32'(m_se));
        check({tag, ".s"}, 32'(s), 32'(m_s));
        if (v.use_exp) begin
            check({tag, ".tbl_se"}, 32'(state_enable), 32'(v.exp_se));
            check({tag, ".tbl_s"}, 32'(s), 32'(v.exp_s));
        end
        do_push = v.iv && m_ready;
        do_pop  = v.rd && opq.size() > 0;
        if (do_pop) begin
            exp_x = opq.pop_front();
            m_cnt = 0;
        end else if (v.ly && m_se && !v.rd && m_cnt < TERMS - 1) begin
            m_cnt++;
        end
        if (do_push) opq.push_back(v.id);
        if (v.dn && m_se) begin
            m_res   = v.ri;
            m_valid = 1'b1;
        end else if (m_valid && v.rr) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, ".x_out"}, 32'(x_out), 32'(exp_x));
        check({tag, ".result_out"}, 32'(result_out), 32'(m_res));
        check({tag, ".result_valid"}, 32'(result_valid), 32'(m_valid));
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_data = '0; read = 0; load_y = 0;
        done = 0; result_in = '0; result_ready = 0;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic apply_reset(input string tag);
        reset = 1'b1;
        idle_inputs();
        #2;
        check({tag, ".rst_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".rst_se"}, 32'(state_enable), 32'd1);
        check({tag, ".rst_s"}, 32'(s), 32'd0);
        check({tag, ".rst_x_out"}, 32'(x_out), 32'd0);
        check({tag, ".rst_result_out"}, 32'(result_out), 32'd0);
        check({tag, ".rst_result_valid"}, 32'(result_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        opq.delete();
        m_cnt = 0; m_valid = 1'b0; m_res = '0; exp_x = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        // Loop-exit walk: push, pop, four load_y pulses, capture, then an empty-stall refill.
        tbl[0]  = mk(1, 16'h1111, 0, 0, 0, 16'h0000, 1, 1, 1, 0);
        tbl[1]  = mk(0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 1, 0);
        tbl[2]  = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 1, 1, 1, 0);
        tbl[3]  = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 1, 1, 1, 0);
        tbl[4]  = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 1, 1, 1, 0);
        tbl[5]  = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 1, 1, 1, 1);
        tbl[6]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 1, 1);
        tbl[7]  = mk(0, 16'h0000, 0, 0, 1, 16'h1234, 1, 1, 1, 1);
        tbl[8]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 1, 1);
        tbl[9]  = mk(0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 0, 1);
        tbl[10] = mk(1, 16'h0005, 1, 0, 0, 16'h0000, 1, 1, 0, 1);
        tbl[11] = mk(0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 1, 1);
        tbl[12] = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 1, 0);

        apply_reset("init");
        for (int i = 0; i < 13; i++) begin
            cycle($sformatf("tbl%0d", i), tbl[i]);
        end

        // Reset mid-run with buffered words, a live operand and a pending result.
        for (int i = 0; i < 3; i++) cycle("mid_push", mk(1, 16'hA001 + 16'(i), 0, 0, 0, 16'h0, 0, 0, 0, 0));
        cycle("mid_pop", mk(0, 16'h0, 1, 0, 0, 16'h0, 0, 0, 0, 0));
        cycle("mid_cap", mk(0, 16'h0, 0, 0, 1, 16'h0077, 0, 0, 0, 0));
        apply_reset("mid");
        cycle("mid_after", mk(0, 16'h0, 1, 0, 0, 16'h0, 0, 1, 0, 0));

        // Empty stall for five cycles, then a push releases it.
        for (int i = 0; i < 5; i++) cycle("estall", mk(0, 16'h0, 1, 0, 0, 16'h0, 1, 1, 0, 0));
        cycle("estall_push", mk(1, 16'h0003, 1, 0, 0, 16'h0, 1, 1, 0, 0));
        cycle("estall_pop", mk(0, 16'h0, 1, 0, 0, 16'h0, 1, 1, 1, 0));
        check("estall_x_out", 32'(x_out), 32'h0003);
        cycle("estall_idle", mk(0, 16'h0, 0, 0, 0, 16'h0, 1, 0, 0, 0));

        // Fill to DEPTH, then pop while offering a push that must be refused.
        for (int i = 0; i < DEPTH; i++) cycle("full_push", mk(1, 16'h0A00 + 16'(i), 0, 0, 0, 16'h0, 1, 1, 1, 0));
        check("full_in_ready_low", 32'(in_ready), 32'd0);
        cycle("full_popush", mk(1, 16'hDEAD, 1, 0, 0, 16'h0, 1, 1, 1, 0));
        check("full_in_ready_back", 32'(in_ready), 32'd1);
        check("full_first_word", 32'(x_out), 32'h0A00);
        for (int i = 0; i < DEPTH - 1; i++) cycle("full_drain", mk(0, 16'h0, 1, 0, 0, 16'h0, 1, 1, 1, 0));
        check("full_last_word", 32'(x_out), 32'h0A03);
        cycle("full_empty", mk(0, 16'h0, 1, 0, 0, 16'h0, 1, 1, 0, 0));

        // Result backpressure and same-edge recapture.
        cycle("bp_cap", mk(0, 16'h0, 0, 0, 1, 16'h00AA, 0, 1, 1, 0));
        for (int i = 0; i < 2; i++) cycle("bp_stall", mk(0, 16'h0, 0, 0, 1, 16'h00BB, 0, 1, 0, 0));
        check("bp_held_value", 32'(result_out), 32'h00AA);
        cycle("bp_recap", mk(0, 16'h0, 0, 0, 1, 16'h00BB, 1, 1, 1, 0));
        check("bp_new_value", 32'(result_out), 32'h00BB);
        check("bp_valid_held", 32'(result_valid), 32'd1);
        cycle("bp_drain", mk(0, 16'h0, 0, 0, 0, 16'h0, 1, 1, 1, 0));
        check("bp_valid_clear", 32'(result_valid), 32'd0);

        idle_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
